// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned IDX_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [IDX_W_DEF-1:0]  index;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and a zero-latency head read.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push while full is only legal when the head leaves in the same cycle.
  always_comb begin
    push_ok  = push_i & (~full_q | pop_i);
    pop_ok   = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch pointer, credit-limited imem requests, redirect flush with stale-response
// dropping, and an in-order instruction buffer toward decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [IDX_W-1:0]  redirect_index,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [IDX_W-1:0]  imem_req_index,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [IDX_W-1:0]  inst_index,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned SUM_W = CNT_W + 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] fetch_ptr_q, fetch_ptr_d, rsp_ptr_q, rsp_ptr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
  logic             req_fire, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  entry_t           push_entry, head_entry;

  // Credits cover both in-flight requests and buffered words, so a push always has room.
  always_comb begin
    state_d        = state_q;
    fetch_ptr_d    = fetch_ptr_q;
    rsp_ptr_d      = rsp_ptr_q;
    drop_d         = drop_q;
    push_entry     = '{data: imem_rsp_data, index: rsp_ptr_q};
    imem_req_valid = fetch_en & ~redirect_valid & ~reset &
                     ((SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH));
    req_fire       = imem_req_valid & imem_req_ready;
    pop            = inst_valid & inst_ready;
    push           = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
    outstanding_d  = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (redirect_valid) begin
      fetch_ptr_d = redirect_index;
      rsp_ptr_d   = redirect_index;
      drop_d      = outstanding_d;
    end else begin
      fetch_ptr_d = fetch_ptr_q + IDX_W'(req_fire);
      if (push) rsp_ptr_d = rsp_ptr_q + IDX_W'(1);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (drop_d != '0)  state_d = ST_DRAIN;
        else if (fetch_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (drop_d != '0)  state_d = ST_DRAIN;
        else if (!fetch_en) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (drop_d == '0) state_d = fetch_en ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fetch_ptr_q   <= '0;
      rsp_ptr_q     <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_ptr_q   <= fetch_ptr_d;
      rsp_ptr_q     <= rsp_ptr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head_entry)
  );

  assign imem_req_index = fetch_ptr_q;
  assign inst_valid     = ~fifo_empty;
  assign inst_data      = head_entry.data;
  assign inst_index     = head_entry.index;
  assign count          = fifo_count;

  push_never_overflows: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule
